key_event_ctrl: RTL
===================

Name: key_event_ctrl

Overview:
- Front-end for the matrix CPU's six buttons: btn[3:0], A, B. Sits directly upstream of the CPU's button register and interrupt-vector logic.
- Synchronises and debounces the raw active-low inputs and generates press and auto-repeat key events.
- Presents the highest-priority pending event to the CPU as an interrupt request with a jump vector, held until the CPU acknowledges it.
- Replaces raw-level polling in the CPU, which repeated uncontrollably while a key was held.

Parameters:
- DEB_TICKS, 4: consecutive ticks of stable input needed to change a debounced level (1..255).
- REPEAT_DELAY, 500: ticks a key must be held after its press event before the first repeat event (1..65535).
- REPEAT_RATE, 100: ticks between subsequent repeat events while held (1..65535).
- VEC_BASE, 2: interrupt vector of key 0.
- VEC_STRIDE, 2: vector spacing between keys.

Ports:
- clock  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick  in  1  single-cycle timebase enable; all debounce and repeat timing counts ticks.
- btn_n  in  6  raw buttons, active-low, asynchronous. Bit map: [5:2]=btn[3:0], [1]=A, [0]=B.
- key_level  out  6  debounced pressed state, active-high.
- irq  out  1  interrupt request.
- irq_key  out  3  index 0..5 of the presented key.
- irq_vec  out  8  VEC_BASE + VEC_STRIDE*irq_key, modulo 256.
- irq_ack  in  1  single-cycle acknowledge from the CPU.
- overrun  out  1  one-cycle pulse when an event arrives for a key whose pending bit is already set.

Behaviour:
- Reset (rst=0, asynchronous):
  - sync flops = 1 (released); key_level = 0; pending = 0; all counters = 0; every key FSM in IDLE.
  - irq = 0, irq_key = 0, irq_vec = VEC_BASE, overrun = 0.
  - Reset mid-hold or with an event pending discards everything. After release, a still-held key must re-debounce and produce a fresh press event.
- Sync: each btn_n bit passes through a 2-flop synchroniser; s = ~synced (pressed = 1).
- Debounce, per key, 8-bit counter:
  - On tick, if s != key_level, the counter increments; if s == key_level, the counter clears. Without tick the counter holds.
  - When the counter reaches DEB_TICKS, key_level toggles and the counter clears in the same clock.
  - Glitches shorter than DEB_TICKS ticks never change key_level.
- Key FSM, per key, with a 16-bit repeat counter:
  - IDLE: on key_level 0->1, set pending[k], clear the counter, go to DELAY.
  - DELAY: on each tick the counter increments. At REPEAT_DELAY it sets pending[k], clears, and goes to REPEAT.
  - REPEAT: on each tick the counter increments. At REPEAT_RATE it sets pending[k] and clears.
  - Any state: key_level 1->0 returns the FSM to IDLE and clears the counter. Release generates no event. pending[k] is left unchanged.
- Event coalescing: if pending[k] is already 1 when a new event occurs, pending stays 1 and overrun pulses high for one clock.
- Priority: highest index wins (key 5 = btn[3] highest, key 0 = B lowest).
- Output registers:
  - Each clock, irq <= |pending_next, and irq_key/irq_vec <= encode(pending_next).
  - irq therefore rises exactly 1 clock after the clock that sets pending.
  - While irq = 1 and irq_ack = 0, irq_key and irq_vec are held even if a higher-priority event arrives. Re-arbitration happens only after an ack or while irq = 0.
- Acknowledge:
  - irq_ack = 1 while irq = 1 clears pending[irq_key].
  - If that same key raises a new event in the same clock, the set wins and pending stays 1 (no overrun).
  - irq_ack while irq = 0 is ignored.
  - After an ack, irq drops for one clock at minimum (registered re-evaluation), then re-asserts if other bits are pending.
- Latency with tick held at 1: a raw falling edge first sampled at clock k gives key_level = 1 at clock k+1+DEB_TICKS and irq = 1 at k+2+DEB_TICKS.
- Widths: vector arithmetic is 8-bit and wraps; counters saturate-free because both are cleared at their terminal values.

Test Plan (tick=1 unless noted; DEB_TICKS=4, REPEAT_DELAY=20, REPEAT_RATE=5, VEC_BASE=2, VEC_STRIDE=2):
- Press key 5, low held 30 clocks -> key_level[5]=1 at clock 5 after first sample; irq=1 at clock 6 with irq_key=5, irq_vec=12. Ack -> irq=0 next clock.
- 3-clock low glitch on key 1 -> key_level, irq and pending stay 0 throughout.
- Hold key 0, acking every request immediately -> press event, then first repeat 20 ticks later, then repeats every 5 ticks, each giving irq_vec=2. Release -> no further irq.
- Press key 0, then key 4 before acking -> irq holds key 0 / vec 2 until ack. After the ack, irq drops one clock, then shows key 4 / vec 10.
- Hold key 2 with no ack through 2 repeats -> overrun pulses twice, one ack clears it, and irq falls.
- Assert rst low mid-DELAY with pending set -> all outputs return to reset values immediately. On release, with the key still held, a new press event (irq, vec 6) follows after debounce.

Source files
------------

// File: rtl/key_event_ctrl_if.sv
// Interrupt handshake between the button front-end and the CPU vector logic.
// The front-end is master: it raises irq with key/vector, the CPU returns a one-cycle ack.
interface key_event_ctrl_if;
  logic       irq;
  logic [2:0] irq_key;
  logic [7:0] irq_vec;
  logic       irq_ack;

  modport master (output irq, irq_key, irq_vec, input irq_ack);
  modport slave  (input irq, irq_key, irq_vec, output irq_ack);
endinterface

// File: rtl/key_event_ctrl.sv
// Six-button front-end: sync, debounce, press/auto-repeat events, priority
// interrupt presentation held until acknowledged.
module key_event_lane #(
  parameter int DEB_TICKS    = 4,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic clock,
  input  logic rst,
  input  logic tick_i,
  input  logic btn_n_i,
  output logic level_o,
  output logic ev_o
);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} st_e;

  localparam logic [7:0]  DEB = 8'(DEB_TICKS);
  localparam logic [15:0] RD  = 16'(REPEAT_DELAY);
  localparam logic [15:0] RR  = 16'(REPEAT_RATE);

  logic [1:0]  sync_q;
  logic [7:0]  deb_q;
  logic        level_q;
  st_e         st_q;
  logic [15:0] rep_q;
  logic        pressed;
  logic [7:0]  deb_inc;
  logic [15:0] rep_inc;

  assign pressed = ~sync_q[1];
  assign deb_inc = deb_q + 8'd1;
  assign rep_inc = rep_q + 16'd1;
  assign level_o = level_q;

  // Press fires on the first clock the FSM sees the new debounced level.
  assign ev_o = level_q &&
                ((st_q == IDLE) ||
                 (tick_i && st_q == DELAY  && rep_inc == RD) ||
                 (tick_i && st_q == REPEAT && rep_inc == RR));

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      deb_q   <= '0;
      level_q <= 1'b0;
      st_q    <= IDLE;
      rep_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_n_i};

      if (tick_i) begin
        if (pressed == level_q)  deb_q <= '0;
        else if (deb_inc == DEB) begin
          deb_q   <= '0;
          level_q <= ~level_q;
        end else                 deb_q <= deb_inc;
      end

      if (!level_q) begin
        st_q  <= IDLE;
        rep_q <= '0;
      end else begin
        case (st_q)
          IDLE: begin
            st_q  <= DELAY;
            rep_q <= '0;
          end
          DELAY: if (tick_i) begin
            if (rep_inc == RD) begin
              st_q  <= REPEAT;
              rep_q <= '0;
            end else rep_q <= rep_inc;
          end
          REPEAT: if (tick_i) rep_q <= (rep_inc == RR) ? '0 : rep_inc;
          default: begin
            st_q  <= IDLE;
            rep_q <= '0;
          end
        endcase
      end
    end
  end
endmodule

module key_event_ctrl #(
  parameter int DEB_TICKS    = 4,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int VEC_BASE     = 2,
  parameter int VEC_STRIDE   = 2
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                tick,
  input  logic [5:0]          btn_n,
  output logic [5:0]          key_level,
  output logic                overrun,
  key_event_ctrl_if.master    cpu
);
  localparam int NUM_LANES = 6;

  logic [NUM_LANES-1:0] ev;
  logic [NUM_LANES-1:0] pending_q, pending_d, clr;
  logic                 irq_q;
  logic [2:0]           irq_key_q;
  logic [7:0]           irq_vec_q;
  logic                 overrun_q, overrun_d;
  logic                 ack_ok;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    key_event_lane #(
      .DEB_TICKS   (DEB_TICKS),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_lane (
      .clock  (clock),
      .rst    (rst),
      .tick_i (tick),
      .btn_n_i(btn_n[k]),
      .level_o(key_level[k]),
      .ev_o   (ev[k])
    );
  end

  function automatic logic [2:0] enc(input logic [NUM_LANES-1:0] p);
    enc = '0;
    for (int i = 0; i < NUM_LANES; i++) if (p[i]) enc = 3'(i);
  endfunction

  function automatic logic [7:0] vec_of(input logic [2:0] key);
    vec_of = 8'(VEC_BASE + VEC_STRIDE * int'(key));
  endfunction

  assign ack_ok    = irq_q & cpu.irq_ack;
  assign clr       = ack_ok ? (NUM_LANES'(1) << irq_key_q) : '0;
  // A new event on the key being acked wins over the clear and is not an overrun.
  assign pending_d = (pending_q & ~clr) | ev;
  assign overrun_d = |(ev & pending_q & ~clr);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
      irq_key_q <= '0;
      irq_vec_q <= 8'(VEC_BASE);
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      // Presented key is frozen while unacked; an ack forces one idle clock.
      if (ack_ok) irq_q <= 1'b0;
      else if (!irq_q) begin
        irq_q     <= |pending_d;
        irq_key_q <= enc(pending_d);
        irq_vec_q <= vec_of(enc(pending_d));
      end
    end
  end

  assign cpu.irq     = irq_q;
  assign cpu.irq_key = irq_key_q;
  assign cpu.irq_vec = irq_vec_q;
  assign overrun     = overrun_q;
endmodule
